mult_share_arbiter: RTL and testbench

- Shares one sequential 8x8 multiplier (start/done controlled) between two requesters.
- Each requester presents operands with a level request. The block picks a requester round-robin, latches its operands, pulses the multiplier start and waits for done. It then captures the product and returns it with a one-cycle acknowledge.
- Sits between requesting masters and the multiplier datapath/controller pair.

---
 rtl/mult_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one sequential WIDTH x WIDTH multiplier between two requesters.
// The arbiter picks a requester round-robin, registers its operands, pulses
// mult_start, waits for mult_done and returns the full 2*WIDTH product with
// a one-cycle acknowledge.
//
// Optional feature, macro ARB_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES
// cycles without mult_done. The requester then gets ack plus err and a zero
// result. TIMEOUT_CYCLES and the err0/err1 ports exist only in that build.
module mult_share_arbiter #(
  parameter int WIDTH = 8
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] result0,
  output logic [2*WIDTH-1:0] result1,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_dataa,
  output logic [WIDTH-1:0]   mult_datab,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product,
  output logic               busy,
  output logic               grant_id,
  output logic [1:0]         state_out
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               err0,
  output logic               err1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_WAIT   = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  state_e               state_q;
  logic                 last_grant_q;
  logic                 grant_q;
  logic [WIDTH-1:0]     dataa_q;
  logic [WIDTH-1:0]     datab_q;
  logic [2*WIDTH-1:0]   result0_q;
  logic [2*WIDTH-1:0]   result1_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic                 win_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]     tmo_cnt_q;
  logic                 err0_q;
  logic                 err1_q;
`endif

  // Round-robin pick: a lone request wins outright, a tie goes to the
  // requester that was not served last.
  always_comb begin
    // NOTE: default first so every path assigns win_d; otherwise a latch is inferred.
    win_d = 1'b0;
    if (req0 && req1) begin
      win_d = ~last_grant_q;
    end else if (req1) begin
      win_d = 1'b1;
    end
  end

  // Arbitration FSM with registered operands, results, acks and error flags.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      // NOTE: results are ordinary output registers, so they are cleared with
      // everything else; an aborted transfer leaves no stale product behind.
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      dataa_q      <= '0;
      datab_q      <= '0;
      result0_q    <= '0;
      result1_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register updates
      // from pre-edge values regardless of statement order.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err0_q <= 1'b0;
      err1_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            grant_q      <= win_d;
            last_grant_q <= win_d;
            dataa_q      <= win_d ? a1 : a0;
            datab_q      <= win_d ? b1 : b0;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // mult_done is deliberately not looked at in the start cycle.
          state_q <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (mult_done) begin
            if (grant_q) result1_q <= mult_product;
            else         result0_q <= mult_product;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= S_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (grant_q) result1_q <= '0;
            else         result0_q <= '0;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            err0_q  <= ~grant_q;
            err1_q  <= grant_q;
            state_q <= S_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign result0    = result0_q;
  assign result1    = result1_q;
  assign mult_start = (state_q == S_LAUNCH);
  assign mult_dataa = dataa_q;
  assign mult_datab = datab_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign state_out  = state_q;
`ifdef ARB_TIMEOUT_EN
  assign err0       = err0_q;
  assign err1       = err1_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: a transaction-level model predicts each
// grant and product from the requesters' inputs, pushes it on a queue, and an
// independent monitor pops and compares whenever the DUT starts or acks.
module tb_mult_share_arbiter;
  localparam int W  = 8;
  localparam int TO = 15;

  typedef struct {
    int who;
    int a;
    int b;
    int prod;
    bit err;
  } txn_t;

  logic           clk = 1'b0;
  logic           reset_a;
  logic           req_v [2];
  logic [W-1:0]   a_v [2];
  logic [W-1:0]   b_v [2];
  logic           mul_pulse;
  logic           hold_done;
  logic           mult_done;
  logic [2*W-1:0] mul_prod;
  logic           ack0, ack1, mult_start, busy, grant_id;
  logic [2*W-1:0] result0, result1;
  logic [W-1:0]   mult_dataa, mult_datab;
  logic [1:0]     state_out;
`ifdef ARB_TIMEOUT_EN
  logic           err0, err1;
`endif

  assign mult_done = mul_pulse | hold_done;

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req0         (req_v[0]),
    .req1         (req_v[1]),
    .a0           (a_v[0]),
    .b0           (b_v[0]),
    .a1           (a_v[1]),
    .b1           (b_v[1]),
    .ack0         (ack0),
    .ack1         (ack1),
    .result0      (result0),
    .result1      (result1),
    .mult_start   (mult_start),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_done    (mult_done),
    .mult_product (mul_prod),
    .busy         (busy),
    .grant_id     (grant_id),
    .state_out    (state_out)
`ifdef ARB_TIMEOUT_EN
    ,
    .err0         (err0),
    .err1         (err1)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  txn_t exp_q [$];

  // Reference model state (edge-indexed).
  int cyc        = 0;
  int grant_edge = -100;
  int done_edge  = -100;
  int free_edge  = 0;
  bit busy_m     = 1'b0;
  int last_m     = 1;

  // Observation counters.
  int start_cnt  = 0;
  int ack_cnt [2];
  int wait_cnt   = 0;

  // Multiplier stand-in controls.
  int fixed_lat  = 0;
  bit no_done    = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  // Waits (bounded) for an ack, then returns #1 after the edge that sees it.
  task automatic wait_ack(output int who, input int budget);
    who = -1;
    for (int c = 0; c < budget && who < 0; c++) begin
      @(negedge clk);
      if (ack0)      who = 0;
      else if (ack1) who = 1;
    end
    check("ack_seen", int'(who >= 0), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_a = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_a = 1'b1;
  endtask

  // Random requester: level request, drop on ack edge or keep it as a new request.
  task automatic requester(input int k, input int n);
    int got;
    for (int i = 0; i < n; i++) begin
      if (!req_v[k]) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      a_v[k]   = W'($urandom);
      b_v[k]   = W'($urandom);
      req_v[k] = 1'b1;
      got = 0;
      for (int c = 0; c < 200 && got == 0; c++) begin
        @(negedge clk);
        if ((k == 0) ? ack0 : ack1) got = 1;
      end
      check("req_served", got, 1);
      @(posedge clk);
      #1;
      if ($urandom_range(0, 2) != 0 || i == n - 1) req_v[k] = 1'b0;
    end
  endtask

  // Multiplier stand-in: latches operands on start, raises done for one cycle later.
  initial begin : mult_model
    int pend;
    logic [2*W-1:0] op_a, op_b;
    pend = 0; op_a = '0; op_b = '0;
    mul_pulse = 1'b0;
    mul_prod  = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_pulse = 1'b0;
      mul_prod  = (2*W)'($urandom);
      if (!reset_a) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0 && !no_done) begin
            mul_pulse = 1'b1;
            mul_prod  = op_a * op_b;
          end
        end
        if (mult_start) begin
          op_a = {8'd0, mult_dataa};
          op_b = {8'd0, mult_datab};
          pend = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
        end
      end
    end
  end

  // Reference model: decides grants and completions from the arbitration rules.
  initial begin : ref_model
    int   w, pa, pb;
    txn_t t;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_a) begin
        exp_q.delete();
        busy_m = 1'b0; last_m = 1; free_edge = 0;
        done_edge = -100; grant_edge = -100;
      end else if (busy_m) begin
        if (mult_done && cyc > grant_edge + 1) begin
          busy_m = 1'b0; done_edge = cyc; free_edge = cyc + 2;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cyc == grant_edge + 1 + TO) begin
          exp_q[0].prod = 0;
          exp_q[0].err  = 1'b1;
          busy_m = 1'b0; done_edge = cyc; free_edge = cyc + 2;
        end
`endif
      end else if (cyc >= free_edge && (req_v[0] || req_v[1])) begin
        if (req_v[0] && req_v[1]) w = (last_m == 1) ? 0 : 1;
        else                      w = req_v[1] ? 1 : 0;
        pa = int'(a_v[w]);
        pb = int'(b_v[w]);
        t.who = w; t.a = pa; t.b = pb; t.prod = pa * pb; t.err = 1'b0;
        exp_q.push_back(t);
        last_m = w; busy_m = 1'b1; grant_edge = cyc;
      end
    end
  end

  // Monitor: compares DUT activity against the model's expectations.
  initial begin : monitor
    int   w;
    txn_t e;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (reset_a) begin
        if (state_out == 2'b10) wait_cnt++;
        check("busy", int'(busy), int'(busy_m || cyc == done_edge));
        if (busy_m) begin
          check("dataa_hold", int'(mult_dataa), exp_q[0].a);
          check("datab_hold", int'(mult_datab), exp_q[0].b);
          check("grant_id", int'(grant_id), exp_q[0].who);
        end
        if (mult_start) begin
          start_cnt++;
          check("start_time", cyc, grant_edge);
        end
        if (ack0 || ack1) begin
          w = ack1 ? 1 : 0;
          ack_cnt[w]++;
          check("ack_exclusive", int'(ack0 && ack1), 0);
          check("ack_time", cyc, done_edge);
          check("ack_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ack_who", w, e.who);
            check("result", int'(w ? result1 : result0), e.prod);
`ifdef ARB_TIMEOUT_EN
            check("err", int'(w ? err1 : err0), int'(e.err));
`endif
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          check("err_idle", int'(err0 | err1), 0);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int who;
    reset_a   = 1'b0;
    hold_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(mult_start), 0);
    check("rst_ack", int'({ack1, ack0}), 0);
    check("rst_result0", int'(result0), 0);
    check("rst_result1", int'(result1), 0);
    check("rst_dataa", int'(mult_dataa), 0);
    check("rst_grant", int'(grant_id), 0);
    @(posedge clk);
    #3 reset_a = 1'b1;

    // Single request, multiplier done 5 cycles after start.
    fixed_lat = 5;
    @(posedge clk);
    #1 req_v[0] = 1'b1; a_v[0] = 8'd12; b_v[0] = 8'd13;
    wait_ack(who, 40);
    req_v[0] = 1'b0;
    check("t1_who", who, 0);
    check("t1_result0", int'(result0), 156);
    check("t1_dataa", int'(mult_dataa), 12);
    check("t1_starts", start_cnt, 1);
    check("t1_no_ack1", ack_cnt[1], 0);

    // Simultaneous requests after reset: 0, then 1, then a fresh tie goes to 0.
    fixed_lat = 0;
    do_reset();
    @(posedge clk);
    #1;
    req_v[0] = 1'b1; a_v[0] = 8'd255; b_v[0] = 8'd255;
    req_v[1] = 1'b1; a_v[1] = 8'd3;   b_v[1] = 8'd7;
    wait_ack(who, 40);
    req_v[0] = 1'b0;
    check("tie1_who", who, 0);
    wait_ack(who, 40);
    req_v[1] = 1'b0;
    check("tie2_who", who, 1);
    check("tie_result0", int'(result0), 65025);
    check("tie_result1", int'(result1), 21);
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    wait_ack(who, 40);
    req_v[0] = 1'b0;
    check("tie3_who", who, 0);
    wait_ack(who, 40);
    req_v[1] = 1'b0;

    // req1 held, req0 toggles: grants alternate, one idle cycle between ops.
    req_v[0] = 1'b1; a_v[0] = W'($urandom); b_v[0] = W'($urandom);
    req_v[1] = 1'b1; a_v[1] = W'($urandom); b_v[1] = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      wait_ack(who, 40);
      check("alt_order", who, i % 2);
      if (who == 0) req_v[0] = 1'b0;
      else begin
        a_v[1] = W'($urandom); b_v[1] = W'($urandom);
      end
      @(negedge clk);
      check("alt_gap_idle", int'(busy), 0);
      @(posedge clk);
      #1;
      if (who == 0) begin
        req_v[0] = 1'b1; a_v[0] = W'($urandom); b_v[0] = W'($urandom);
      end
      @(negedge clk);
      check("alt_gap_busy", int'(busy), 1);
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    wait_ack(who, 40);
    check("alt_drain_who", who, 0);

    // Reset in WAIT aborts the operation; the next request completes.
    fixed_lat = 5;
    req_v[0] = 1'b1; a_v[0] = 8'd200; b_v[0] = 8'd100;
    who = 0;
    for (int c = 0; c < 20 && state_out != 2'b10; c++) @(negedge clk);
    check("rst_mid_in_wait", int'(state_out), 2);
    @(posedge clk);
    #3 reset_a = 1'b0;
    req_v[0] = 1'b0;
    #1;
    check("rst_mid_state", int'(state_out), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ack", int'({ack1, ack0}), 0);
    check("rst_mid_result0", int'(result0), 0);
    check("rst_mid_result1", int'(result1), 0);
    repeat (2) @(posedge clk);
    #3 reset_a = 1'b1;
    @(posedge clk);
    #1 req_v[0] = 1'b1; a_v[0] = 8'd7; b_v[0] = 8'd9;
    wait_ack(who, 40);
    req_v[0] = 1'b0;
    check("post_rst_who", who, 0);
    check("post_rst_result0", int'(result0), 63);

    // mult_done held in IDLE and LAUNCH is ignored; req0 dropped after grant,
    // req1 raised and dropped while busy never starts an operation.
    fixed_lat = 3;
    hold_done = 1'b1;
    @(posedge clk);
    #1 req_v[0] = 1'b1; a_v[0] = 8'd20; b_v[0] = 8'd30;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    req_v[1] = 1'b1; a_v[1] = 8'd99; b_v[1] = 8'd99;
    @(posedge clk);
    #1 hold_done = 1'b0;
    req_v[1] = 1'b0;
    wait_ack(who, 40);
    check("hold_who", who, 0);
    check("hold_result0", int'(result0), 600);
    check("hold_result1_kept", int'(result1), 0);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic from both requesters.
    fixed_lat = 0;
    fork
      requester(0, 25);
      requester(1, 25);
    join
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);

`ifdef ARB_TIMEOUT_EN
    // Multiplier never answers: abort after TO WAIT cycles with err0.
    no_done  = 1'b1;
    wait_cnt = 0;
    req_v[0] = 1'b1; a_v[0] = 8'd5; b_v[0] = 8'd6;
    wait_ack(who, 60);
    req_v[0] = 1'b0;
    check("tmo_who", who, 0);
    check("tmo_wait_cycles", wait_cnt, TO);
    check("tmo_result0", int'(result0), 0);
    @(negedge clk);
    check("tmo_idle", int'(state_out), 0);
    no_done = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
